// File: rtl/inst_mem_responder.sv
// inst_mem_responder: DEPTH x 8 instruction store with a wait-state fetch FSM.
// A fetch request is latched in IDLE, held for WAIT_STATES idle cycles, then
// answered with a registered word and a one-cycle ack.
// Optional feature macro: MEM_PARITY_EN. When it is defined, each word keeps an
// even-parity bit, and the parity_err output flags a mismatch on each fetch.
module inst_mem_responder #(
  parameter int WAIT_STATES = 1,
  parameter int DEPTH       = 32
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       req,
  input  logic [4:0] addr,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] rdata,
  output logic       ack,
`ifdef MEM_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] RESPOND = 2'd2;

  logic [1:0] state;
  logic [2:0] cnt;
  logic [4:0] addr_q;
  logic [7:0] mem [DEPTH];
  logic       load;
  logic [4:0] rd_addr;

`ifdef MEM_PARITY_EN
  logic par [DEPTH];

  // A set bit makes the total count of ones in {word, bit} even.
  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  // Decide when rdata reloads and which address it reads. With zero wait
  // states the word comes straight from the live addr input, because addr_q
  // is only being captured on that same edge.
  always_comb begin
    load    = 1'b0;
    rd_addr = addr_q;
    if (state == IDLE) begin
      rd_addr = addr;
      load    = req && (WAIT_STATES == 0);
    end else if (state == WAIT) begin
      load    = (cnt == 3'd1);
    end
  end

  assign ack  = (state == RESPOND);
  assign busy = (state != IDLE);

  // Fetch FSM: capture the request, count the wait states, then respond.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            addr_q <= addr;
            cnt    <= 3'(WAIT_STATES);
            state  <= (WAIT_STATES == 0) ? RESPOND : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= RESPOND;
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output word register. It reads the pre-edge memory contents, so a write
  // that lands on the same edge is not returned.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      rdata <= '0;
`ifdef MEM_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else if (load) begin
      rdata <= mem[rd_addr];
`ifdef MEM_PARITY_EN
      parity_err <= (even_par(mem[rd_addr]) != par[rd_addr]);
`endif
    end
  end

  // Program-load port. It is independent of the FSM, so writes never stall
  // fetches.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
`ifdef MEM_PARITY_EN
        par[i] <= 1'b0;
`endif
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
`ifdef MEM_PARITY_EN
      par[wr_addr] <= even_par(wr_data);
`endif
    end
  end

endmodule

// File: tb/tb_inst_mem_responder.sv
// Bench for inst_mem_responder: three instances (WAIT_STATES = 1, 0 and 3)
// share one stimulus bus. Table vectors run through a scoreboard queue on the
// WAIT_STATES=1 instance. Hand sequences cover latency, throughput, write/read
// ordering, ignored requests and mid-transaction reset.
module tb_inst_mem_responder;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       req = 1'b0;
  logic [4:0] addr = '0;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_data = '0;

  logic [7:0] rdata1, rdata0, rdata3;
  logic       ack1, ack0, ack3;
  logic       busy1, busy0, busy3;
`ifdef MEM_PARITY_EN
  logic       perr1, perr0, perr3;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  typedef struct {
    logic [4:0] wa;
    logic [7:0] wd;
    logic [4:0] ra;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl [8];

  always #5 clk = ~clk;

  inst_mem_responder #(.WAIT_STATES(1), .DEPTH(32)) u_ws1 (
    .clk(clk), .clear(clear), .req(req), .addr(addr), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rdata(rdata1), .ack(ack1),
`ifdef MEM_PARITY_EN
    .parity_err(perr1),
`endif
    .busy(busy1));

  inst_mem_responder #(.WAIT_STATES(0), .DEPTH(32)) u_ws0 (
    .clk(clk), .clear(clear), .req(req), .addr(addr), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rdata(rdata0), .ack(ack0),
`ifdef MEM_PARITY_EN
    .parity_err(perr0),
`endif
    .busy(busy0));

  inst_mem_responder #(.WAIT_STATES(3), .DEPTH(32)) u_ws3 (
    .clk(clk), .clear(clear), .req(req), .addr(addr), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rdata(rdata3), .ack(ack3),
`ifdef MEM_PARITY_EN
    .parity_err(perr3),
`endif
    .busy(busy3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    wr_en = 1'b0;
    repeat (n) tick();
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%02h want=%02h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0b want=%0b", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit got;
    tbl[0] = '{5'd3,  8'hA5, 5'd3,  8'hA5};
    tbl[1] = '{5'd0,  8'h10, 5'd0,  8'h10};
    tbl[2] = '{5'd1,  8'h11, 5'd1,  8'h11};
    tbl[3] = '{5'd2,  8'h12, 5'd2,  8'h12};
    tbl[4] = '{5'd31, 8'hFF, 5'd31, 8'hFF};
    tbl[5] = '{5'd16, 8'h5A, 5'd4,  8'h00};
    tbl[6] = '{5'd16, 8'hC3, 5'd16, 8'hC3};
    tbl[7] = '{5'd8,  8'h01, 5'd3,  8'hA5};

    // reset state
    #2 clear = 1'b0;
    tick(); tick();
    chk1("rst_ack", ack1, 1'b0);
    chk1("rst_busy", busy1, 1'b0);
    chk8("rst_rdata", rdata1, 8'h00);
    chk1("rst_busy3", busy3, 1'b0);
    clear = 1'b1;
    tick();

    // basic latency: WAIT_STATES=1 acks on the second cycle, WAIT_STATES=0 on the first
    wr(5'd3, 8'hA5);
    req = 1'b1; addr = 5'd3;
    tick();
    req = 1'b0;
    chk1("lat_busy1_c1", busy1, 1'b1);
    chk1("lat_ack1_c1", ack1, 1'b0);
    chk1("lat_ack0_c1", ack0, 1'b1);
    chk8("lat_rdata0", rdata0, 8'hA5);
    tick();
    chk1("lat_ack1_c2", ack1, 1'b1);
    chk8("lat_rdata1", rdata1, 8'hA5);
    chk1("lat_busy1_c2", busy1, 1'b1);
    chk1("lat_ack0_c2", ack0, 1'b0);
    tick();
    chk1("lat_ack1_c3", ack1, 1'b0);
    chk1("lat_busy1_c3", busy1, 1'b0);
    chk8("lat_hold1", rdata1, 8'hA5);
    idle(6);

    // table: load all words, then fetch through the scoreboard
    for (int i = 0; i < 8; i++) wr(tbl[i].wa, tbl[i].wd);
    for (int i = 0; i < 8; i++) begin
      req = 1'b1; addr = tbl[i].ra;
      exp_q.push_back(tbl[i].exp);
      tick();
      req = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        if (ack1) begin
          got = 1'b1;
          chk8($sformatf("sb_vec%0d", i), rdata1, exp_q.pop_front());
        end else begin
          tick();
        end
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL sb_timeout_vec%0d got=no_ack want=ack", i);
        void'(exp_q.pop_front());
      end
      tick();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got=%0d want=0", exp_q.size());
    end
    idle(6);

    // back-to-back with req held: WAIT_STATES=0 acks every 2 cycles
    req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      addr = 5'(k);
      tick();
      chk1($sformatf("b2b_ack_%0d", k), ack0, 1'b1);
      chk8($sformatf("b2b_rdata_%0d", k), rdata0, 8'h10 + 8'(k));
      tick();
      chk1($sformatf("b2b_gap_%0d", k), ack0, 1'b0);
    end
    idle(6);

    // write during WAIT is seen; a write on the RESPOND-entry edge is not
    req = 1'b1; addr = 5'd7;
    tick();
    req = 1'b0;
    wr(5'd7, 8'h3C);
    chk1("entry_ack1", ack1, 1'b1);
    chk8("entry_rdata1_old", rdata1, 8'h00);
    tick();
    chk1("wait_ack3_early", ack3, 1'b0);
    tick();
    chk1("wait_ack3", ack3, 1'b1);
    chk8("wait_rdata3_new", rdata3, 8'h3C);
    idle(6);
    wr(5'd7, 8'h00);
    idle(2);
    req = 1'b1; addr = 5'd7;
    tick();
    req = 1'b0;
    tick(); tick();
    wr(5'd7, 8'h3C);
    chk1("entry_ack3", ack3, 1'b1);
    chk8("entry_rdata3_old", rdata3, 8'h00);
    idle(6);

    // requests during WAIT and RESPOND are ignored
    req = 1'b1; addr = 5'd3;
    tick();
    addr = 5'd9;
    tick();
    req = 1'b0;
    tick();
    req = 1'b1; addr = 5'd10;
    tick();
    chk1("ign_ack3", ack3, 1'b1);
    chk8("ign_rdata3", rdata3, 8'hA5);
    addr = 5'd11;
    tick();
    req = 1'b0;
    chk1("ign_busy3_after", busy3, 1'b0);
    chk1("ign_ack3_after", ack3, 1'b0);
    tick();
    chk1("ign_busy3_idle", busy3, 1'b0);
    chk8("ign_hold3", rdata3, 8'hA5);
    idle(6);

    // clear during WAIT aborts with no ack
    req = 1'b1; addr = 5'd3;
    tick();
    req = 1'b0;
    chk1("abort_busy3_pre", busy3, 1'b1);
    #2 clear = 1'b0;
    #1;
    chk1("abort_busy3", busy3, 1'b0);
    chk1("abort_busy1", busy1, 1'b0);
    chk8("abort_rdata3", rdata3, 8'h00);
    chk8("abort_rdata0", rdata0, 8'h00);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk1($sformatf("abort_noack3_%0d", c), ack3, 1'b0);
      chk1($sformatf("abort_noack1_%0d", c), ack1, 1'b0);
    end
    clear = 1'b1;
    // first edge after release: simultaneous write and fetch of address 0
    req = 1'b1; addr = 5'd0;
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 8'h77;
    tick();
    req = 1'b0; wr_en = 1'b0;
    chk1("post_ack0", ack0, 1'b1);
    chk8("post_rdata0", rdata0, 8'h00);
    chk1("post_busy1", busy1, 1'b1);
    tick();
    chk1("post_ack1", ack1, 1'b1);
    chk8("post_rdata1", rdata1, 8'h77);
    req = 1'b1; addr = 5'd3;
    tick();
    req = 1'b0;
    chk1("post_ack0_b", ack0, 1'b1);
    chk8("post_mem_cleared", rdata0, 8'h00);
    idle(6);

`ifdef MEM_PARITY_EN
    // corrupted stored parity is flagged, then a clean fetch clears the flag
    wr(5'd5, 8'h00);
    idle(2);
    u_ws1.par[5] = 1'b1;
    req = 1'b1; addr = 5'd5;
    tick();
    req = 1'b0;
    tick();
    chk1("par_ack", ack1, 1'b1);
    chk1("par_err", perr1, 1'b1);
    idle(4);
    req = 1'b1; addr = 5'd0;
    tick();
    req = 1'b0;
    tick();
    chk1("par_clean", perr1, 1'b0);
    idle(4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
